// File: rtl/llc_snoop_responder_pkg.sv
// Line geometry, bus/snoop enums, FSM states and the snoop action table for the LLC snoop responder.
// Purely combinational helpers; no state lives here.
package llc_snoop_responder_pkg;

  localparam int ADDR_W           = 32;
  localparam int LINE_OFFSET_BITS = 6;
  localparam int INDEX_SIZE       = 14;
  localparam int TAG_SIZE         = ADDR_W - INDEX_SIZE - LINE_OFFSET_BITS;

  typedef enum logic [1:0] {
    MESI_I = 2'd0,
    MESI_S = 2'd1,
    MESI_E = 2'd2,
    MESI_M = 2'd3
  } mesi_e;

  typedef enum logic [2:0] {
    BUS_NONE       = 3'd0,
    BUS_READ       = 3'd1,
    BUS_WRITE      = 3'd2,
    BUS_INVALIDATE = 3'd3,
    BUS_RWIM       = 3'd4
  } bus_operation_e;

  typedef enum logic [1:0] {
    SNP_NOHIT = 2'd0,
    SNP_HIT   = 2'd1,
    SNP_HITM  = 2'd2
  } snoop_result_e;

  typedef enum logic [2:0] {
    L1_NONE           = 3'd0,
    L1_GETLINE        = 3'd1,
    L1_SENDLINE       = 3'd2,
    L1_INVALIDATELINE = 3'd3,
    L1_EVICTLINE      = 3'd4
  } l2_l1_msg_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOOKUP  = 3'd1,
    ST_RESPOND = 3'd2,
    ST_GETLINE = 3'd3,
    ST_WB      = 3'd4,
    ST_INVAL   = 3'd5,
    ST_UPDATE  = 3'd6
  } snp_state_e;

  typedef struct packed {
    snoop_result_e res;
    logic          getline;
    logic          wb;
    logic          inval;
    logic          upd;
    mesi_e         new_mesi;
  } snoop_action_t;

  localparam snoop_action_t ACT_NONE = '{res: SNP_NOHIT, getline: 1'b0, wb: 1'b0,
                                         inval: 1'b0, upd: 1'b0, new_mesi: MESI_I};

  // A line in I is treated exactly like a tag miss for every operation.
  function automatic snoop_action_t snoop_action(bus_operation_e op, logic hit, mesi_e mesi);
    snoop_action_t a;
    a = ACT_NONE;
    if (hit && (mesi != MESI_I)) begin
      case (op)
        BUS_READ: begin
          case (mesi)
            MESI_M: begin
              a.res      = SNP_HITM;
              a.getline  = 1'b1;
              a.wb       = 1'b1;
              a.upd      = 1'b1;
              a.new_mesi = MESI_S;
            end
            MESI_E: begin
              a.res      = SNP_HIT;
              a.upd      = 1'b1;
              a.new_mesi = MESI_S;
            end
            default: a.res = SNP_HIT;
          endcase
        end
        BUS_RWIM: begin
          a.inval    = 1'b1;
          a.upd      = 1'b1;
          a.new_mesi = MESI_I;
          if (mesi == MESI_M) begin
            a.res     = SNP_HITM;
            a.getline = 1'b1;
            a.wb      = 1'b1;
          end else begin
            a.res = SNP_HIT;
          end
        end
        BUS_INVALIDATE: begin
          // E/M here is a protocol error upstream; respond NOHIT and leave the line alone.
          if (mesi == MESI_S) begin
            a.res      = SNP_HIT;
            a.inval    = 1'b1;
            a.upd      = 1'b1;
            a.new_mesi = MESI_I;
          end
        end
        default: a = ACT_NONE;
      endcase
    end
    return a;
  endfunction

  // Follow-up stages run in a fixed order; skip any the action does not need.
  function automatic snp_state_e next_stage(snp_state_e cur, snoop_action_t a);
    snp_state_e n;
    n = ST_IDLE;
    if ((cur == ST_RESPOND) && a.getline)
      n = ST_GETLINE;
    else if (((cur == ST_RESPOND) || (cur == ST_GETLINE)) && a.wb)
      n = ST_WB;
    else if (((cur == ST_RESPOND) || (cur == ST_GETLINE) || (cur == ST_WB)) && a.inval)
      n = ST_INVAL;
    else if (((cur == ST_RESPOND) || (cur == ST_GETLINE) || (cur == ST_WB) ||
              (cur == ST_INVAL)) && a.upd)
      n = ST_UPDATE;
    return n;
  endfunction

endpackage

// File: rtl/llc_snoop_responder_if.sv
// Snoop port, tag-array lookup, result, L1 message, writeback and MESI update signals.
// master = the responder, slave = bus/tag-array/L1 environment around it.
interface llc_snoop_responder_if;
  import llc_snoop_responder_pkg::*;

  logic                  snp_valid;
  logic                  snp_ready;
  bus_operation_e        snp_op;
  logic [ADDR_W-1:0]     snp_addr;
  logic [3:0]            snp_cache_id;

  logic                  lk_req;
  logic [INDEX_SIZE-1:0] lk_index;
  logic [TAG_SIZE-1:0]   lk_tag;
  logic                  lk_ack;
  logic                  lk_hit;
  logic [2:0]            lk_way;
  mesi_e                 lk_mesi;

  logic                  res_valid;
  snoop_result_e         res;
  logic [ADDR_W-1:0]     res_addr;

  logic                  l1_valid;
  logic                  l1_ready;
  l2_l1_msg_e            l1_msg;
  logic [ADDR_W-1:0]     l1_addr;

  logic                  wb_valid;
  logic                  wb_ready;
  logic [ADDR_W-1:0]     wb_addr;

  logic                  upd_valid;
  logic [2:0]            upd_way;
  mesi_e                 upd_mesi;

  modport master (
    input  snp_valid, snp_op, snp_addr, snp_cache_id,
    output snp_ready,
    output lk_req, lk_index, lk_tag,
    input  lk_ack, lk_hit, lk_way, lk_mesi,
    output res_valid, res, res_addr,
    output l1_valid, l1_msg, l1_addr,
    input  l1_ready,
    output wb_valid, wb_addr,
    input  wb_ready,
    output upd_valid, upd_way, upd_mesi
  );

  modport slave (
    output snp_valid, snp_op, snp_addr, snp_cache_id,
    input  snp_ready,
    input  lk_req, lk_index, lk_tag,
    output lk_ack, lk_hit, lk_way, lk_mesi,
    input  res_valid, res, res_addr,
    input  l1_valid, l1_msg, l1_addr,
    output l1_ready,
    input  wb_valid, wb_addr,
    output wb_ready,
    input  upd_valid, upd_way, upd_mesi
  );

endinterface

// File: rtl/llc_snoop_responder_stats.sv
// Saturating HIT/HITM/NOHIT counters, one increment per posted snoop result.
// Counts on the cycle after res_valid; never stalls anything.
module llc_snoop_stats
  import llc_snoop_responder_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          res_valid,
  input  snoop_result_e res,
  output logic [31:0]   cnt_hit,
  output logic [31:0]   cnt_hitm,
  output logic [31:0]   cnt_nohit
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_hit   <= '0;
      cnt_hitm  <= '0;
      cnt_nohit <= '0;
    end else if (res_valid) begin
      if ((res == SNP_HIT) && (cnt_hit != '1))
        cnt_hit <= cnt_hit + 32'd1;
      if ((res == SNP_HITM) && (cnt_hitm != '1))
        cnt_hitm <= cnt_hitm + 32'd1;
      if ((res == SNP_NOHIT) && (cnt_nohit != '1))
        cnt_nohit <= cnt_nohit + 32'd1;
    end
  end

endmodule

// File: rtl/llc_snoop_responder.sv
// LLC snoop responder: lookup, HIT/HITM/NOHIT result 2 cycles after accept (combinational ack), then L1/WB/MESI follow-up.
// One snoop at a time; snp_ready only in IDLE; l1/wb held until ready. Statistics counters built only with SNOOP_STATS_EN.
module llc_snoop_responder
  import llc_snoop_responder_pkg::*;
#(
  parameter logic [3:0] OWN_CACHE_ID = 4'd0,
  parameter int         OFFSET_BITS  = LINE_OFFSET_BITS
) (
  input  logic                   clk,
  input  logic                   rst,
  llc_snoop_responder_if.master  bus,
  output logic [31:0]            cnt_hit,
  output logic [31:0]            cnt_hitm,
  output logic [31:0]            cnt_nohit
);

  snp_state_e        state;
  snp_state_e        nxt;
  bus_operation_e    op_q;
  logic [ADDR_W-1:0] addr_q;
  snoop_action_t     act_q;
  logic [2:0]        way_q;

  logic       snp_ready_q;
  logic       lk_req_q;
  logic       res_valid_q;
  logic       l1_valid_q;
  l2_l1_msg_e l1_msg_q;
  logic       wb_valid_q;
  logic       upd_valid_q;

  logic fwd;
  assign fwd = bus.snp_valid && snp_ready_q && (bus.snp_cache_id != OWN_CACHE_ID);

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:    if (fwd)          nxt = ST_LOOKUP;
      ST_LOOKUP:  if (bus.lk_ack)   nxt = ST_RESPOND;
      ST_RESPOND:                   nxt = next_stage(ST_RESPOND, act_q);
      ST_GETLINE: if (bus.l1_ready) nxt = next_stage(ST_GETLINE, act_q);
      ST_WB:      if (bus.wb_ready) nxt = next_stage(ST_WB, act_q);
      ST_INVAL:   if (bus.l1_ready) nxt = next_stage(ST_INVAL, act_q);
      ST_UPDATE:                    nxt = ST_IDLE;
      default:                      nxt = ST_IDLE;
    endcase
  end

  // Handshake outputs are decoded from the next state so they are plain flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      snp_ready_q <= 1'b1;
      lk_req_q    <= 1'b0;
      res_valid_q <= 1'b0;
      l1_valid_q  <= 1'b0;
      l1_msg_q    <= L1_NONE;
      wb_valid_q  <= 1'b0;
      upd_valid_q <= 1'b0;
    end else begin
      state       <= nxt;
      snp_ready_q <= (nxt == ST_IDLE);
      lk_req_q    <= (nxt == ST_LOOKUP);
      res_valid_q <= (nxt == ST_RESPOND);
      l1_valid_q  <= (nxt == ST_GETLINE) || (nxt == ST_INVAL);
      wb_valid_q  <= (nxt == ST_WB);
      upd_valid_q <= (nxt == ST_UPDATE);
      if (nxt == ST_GETLINE)
        l1_msg_q <= L1_GETLINE;
      else if (nxt == ST_INVAL)
        l1_msg_q <= L1_INVALIDATELINE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= BUS_NONE;
      addr_q <= '0;
      act_q  <= ACT_NONE;
      way_q  <= '0;
    end else begin
      if ((state == ST_IDLE) && fwd) begin
        op_q   <= bus.snp_op;
        addr_q <= bus.snp_addr;
      end
      if ((state == ST_LOOKUP) && bus.lk_ack) begin
        act_q <= snoop_action(op_q, bus.lk_hit, bus.lk_mesi);
        way_q <= bus.lk_way;
      end
    end
  end

  logic [ADDR_W-1:0] line_addr;
  assign line_addr = {addr_q[ADDR_W-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};

  assign bus.snp_ready = snp_ready_q;
  assign bus.lk_req    = lk_req_q;
  assign bus.lk_index  = addr_q[OFFSET_BITS +: INDEX_SIZE];
  assign bus.lk_tag    = addr_q[OFFSET_BITS + INDEX_SIZE +: TAG_SIZE];
  assign bus.res_valid = res_valid_q;
  assign bus.res       = act_q.res;
  assign bus.res_addr  = addr_q;
  assign bus.l1_valid  = l1_valid_q;
  assign bus.l1_msg    = l1_msg_q;
  assign bus.l1_addr   = line_addr;
  assign bus.wb_valid  = wb_valid_q;
  assign bus.wb_addr   = line_addr;
  assign bus.upd_valid = upd_valid_q;
  assign bus.upd_way   = way_q;
  assign bus.upd_mesi  = act_q.new_mesi;

`ifdef SNOOP_STATS_EN
  llc_snoop_stats u_stats (
    .clk       (clk),
    .rst       (rst),
    .res_valid (res_valid_q),
    .res       (act_q.res),
    .cnt_hit   (cnt_hit),
    .cnt_hitm  (cnt_hitm),
    .cnt_nohit (cnt_nohit)
  );
`else
  assign cnt_hit   = '0;
  assign cnt_hitm  = '0;
  assign cnt_nohit = '0;
`endif

endmodule

// File: tb/tb_llc_snoop_responder.sv
// Directed snoops with hand-computed expected events queued in order; a negedge monitor pops and compares every result/L1/WB/update handshake.
module tb_llc_snoop_responder;
  import llc_snoop_responder_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cnt_hit, cnt_hitm, cnt_nohit;

  llc_snoop_responder_if bif();
  assign bif.lk_ack = bif.lk_req;

  llc_snoop_responder #(.OWN_CACHE_ID(4'd0), .OFFSET_BITS(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bif),
    .cnt_hit   (cnt_hit),
    .cnt_hitm  (cnt_hitm),
    .cnt_nohit (cnt_nohit)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;   // 0 result, 1 l1 message, 2 writeback, 3 mesi update
    logic [31:0] a;
    logic [31:0] b;
  } ev_t;

  ev_t         exp_q[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          accept_cyc = 0;
  int          upd_cnt = 0;
  int          l1_stall = 0;
  int          wb_stall = 0;
  logic [31:0] cur_addr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic string kname(int k);
    case (k)
      0:       return "res";
      1:       return "l1";
      2:       return "wb";
      default: return "upd";
    endcase
  endfunction

  task automatic expect_ev(int kind, logic [31:0] a, logic [31:0] b);
    exp_q.push_back('{kind: kind, a: a, b: b});
  endtask

  task automatic observe(int kind, logic [31:0] a, logic [31:0] b);
    ev_t e;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_%s: got a=0x%08h b=0x%08h expected no event", kname(kind), a, b);
    end else begin
      e = exp_q.pop_front();
      chk({"order_", kname(e.kind)}, kind, e.kind);
      chk({kname(kind), "_a"}, a, e.a);
      chk({kname(kind), "_b"}, b, e.b);
    end
  endtask

  // Monitor: compares every output event against the scoreboard and checks hold stability.
  initial begin
    logic        l1_hold, wb_hold, lk_p;
    logic [31:0] l1_msg_p, l1_addr_p, wb_addr_p;
    l1_hold = 1'b0; wb_hold = 1'b0; lk_p = 1'b0;
    l1_msg_p = '0; l1_addr_p = '0; wb_addr_p = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        l1_hold = 1'b0; wb_hold = 1'b0; lk_p = 1'b0;
      end else begin
        if (l1_hold) begin
          chk("l1_valid_held", 32'(bif.l1_valid), 1);
          chk("l1_msg_stable", 32'(bif.l1_msg), l1_msg_p);
          chk("l1_addr_stable", bif.l1_addr, l1_addr_p);
        end
        if (wb_hold) begin
          chk("wb_valid_held", 32'(bif.wb_valid), 1);
          chk("wb_addr_stable", bif.wb_addr, wb_addr_p);
        end
        if (bif.lk_req && !lk_p) begin
          chk("lk_index", 32'(bif.lk_index), 32'(cur_addr[19:6]));
          chk("lk_tag", 32'(bif.lk_tag), 32'(cur_addr[31:20]));
        end
        if (bif.res_valid) begin
          chk("res_latency", cyc - accept_cyc, 2);
          observe(0, 32'(bif.res), bif.res_addr);
        end
        if (bif.l1_valid && bif.l1_ready) observe(1, 32'(bif.l1_msg), bif.l1_addr);
        if (bif.wb_valid && bif.wb_ready) observe(2, 0, bif.wb_addr);
        if (bif.upd_valid) begin
          upd_cnt++;
          observe(3, 32'(bif.upd_way), 32'(bif.upd_mesi));
        end
        l1_hold   = bif.l1_valid && !bif.l1_ready;
        l1_msg_p  = 32'(bif.l1_msg);
        l1_addr_p = bif.l1_addr;
        wb_hold   = bif.wb_valid && !bif.wb_ready;
        wb_addr_p = bif.wb_addr;
        lk_p      = bif.lk_req;
      end
    end
  end

  // L1 and bus ready: held low for *_stall cycles of each valid, high otherwise.
  initial begin
    int l1_w, wb_w;
    l1_w = 0; wb_w = 0;
    bif.l1_ready = 1'b1;
    bif.wb_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (bif.l1_valid) begin
        if (l1_w < l1_stall) begin bif.l1_ready = 1'b0; l1_w++; end
        else bif.l1_ready = 1'b1;
      end else begin
        bif.l1_ready = 1'b1; l1_w = 0;
      end
      if (bif.wb_valid) begin
        if (wb_w < wb_stall) begin bif.wb_ready = 1'b0; wb_w++; end
        else bif.wb_ready = 1'b1;
      end else begin
        bif.wb_ready = 1'b1; wb_w = 0;
      end
    end
  end

  task automatic issue(bus_operation_e op, logic [31:0] addr, logic [3:0] id,
                       logic hit, logic [2:0] way, mesi_e mesi);
    int n;
    @(posedge clk); #1;
    bif.lk_hit = hit; bif.lk_way = way; bif.lk_mesi = mesi;
    cur_addr = addr;
    bif.snp_valid = 1'b1; bif.snp_op = op; bif.snp_addr = addr; bif.snp_cache_id = id;
    n = 0;
    @(negedge clk);
    while (!bif.snp_ready && n < 100) begin @(negedge clk); n++; end
    chk("accept_timeout", 32'(bif.snp_ready), 1);
    accept_cyc = cyc;
    @(posedge clk); #1;
    bif.snp_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !bif.snp_ready) && n < 300) begin @(negedge clk); n++; end
    chk("drain_timeout", 32'(n < 300), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    int          upd_before;
    logic        bad;
    bif.snp_valid = 1'b0; bif.snp_op = BUS_NONE; bif.snp_addr = '0; bif.snp_cache_id = '0;
    bif.lk_hit = 1'b0; bif.lk_way = '0; bif.lk_mesi = MESI_I;

    repeat (2) @(negedge clk);
    chk("rst_snp_ready", 32'(bif.snp_ready), 1);
    chk("rst_lk_req", 32'(bif.lk_req), 0);
    chk("rst_res_valid", 32'(bif.res_valid), 0);
    chk("rst_l1_valid", 32'(bif.l1_valid), 0);
    chk("rst_wb_valid", 32'(bif.wb_valid), 0);
    chk("rst_upd_valid", 32'(bif.upd_valid), 0);
    chk("rst_res_addr", bif.res_addr, 0);
    chk("rst_l1_addr", bif.l1_addr, 0);
    chk("rst_wb_addr", bif.wb_addr, 0);
    chk("rst_cnt_hit", cnt_hit, 0);
    chk("rst_cnt_hitm", cnt_hitm, 0);
    chk("rst_cnt_nohit", cnt_nohit, 0);
    @(posedge clk); #1 rst = 1'b0;

    // READ hit M: HITM, GETLINE, WB, M->S
    expect_ev(0, 32'(SNP_HITM), 32'h0000_1040);
    expect_ev(1, 32'(L1_GETLINE), 32'h0000_1040);
    expect_ev(2, 0, 32'h0000_1040);
    expect_ev(3, 3, 32'(MESI_S));
    issue(BUS_READ, 32'h0000_1040, 4'd2, 1'b1, 3'd3, MESI_M);
    drain();

    // RWIM hit E: HIT, INVALIDATELINE, E->I
    expect_ev(0, 32'(SNP_HIT), 32'h0000_2000);
    expect_ev(1, 32'(L1_INVALIDATELINE), 32'h0000_2000);
    expect_ev(3, 5, 32'(MESI_I));
    issue(BUS_RWIM, 32'h0000_2000, 4'd1, 1'b1, 3'd5, MESI_E);
    drain();

    // READ miss: NOHIT only, ready the cycle after the result
    expect_ev(0, 32'(SNP_NOHIT), 32'h0000_3000);
    issue(BUS_READ, 32'h0000_3000, 4'd2, 1'b0, 3'd0, MESI_I);
    n = 0;
    while (!bif.res_valid && n < 20) begin @(negedge clk); n++; end
    chk("miss_res_seen", 32'(bif.res_valid), 1);
    chk("miss_ready_during_res", 32'(bif.snp_ready), 0);
    @(negedge clk);
    chk("miss_ready_after_res", 32'(bif.snp_ready), 1);
    drain();

    // Own ID: dropped without lookup or result
    issue(BUS_READ, 32'h0000_4000, 4'd0, 1'b1, 3'd0, MESI_M);
    bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bif.lk_req || bif.res_valid || !bif.snp_ready) bad = 1'b1;
    end
    chk("own_id_ignored", 32'(bad), 0);

    // READ hit E with nonzero offset: HIT, E->S, full address on result
    expect_ev(0, 32'(SNP_HIT), 32'h0000_6A7F);
    expect_ev(3, 2, 32'(MESI_S));
    issue(BUS_READ, 32'h0000_6A7F, 4'd3, 1'b1, 3'd2, MESI_E);
    drain();

    // RWIM hit M under backpressure: GETLINE -> WB -> INVAL, line address
    l1_stall = 5; wb_stall = 3;
    expect_ev(0, 32'(SNP_HITM), 32'h0000_5093);
    expect_ev(1, 32'(L1_GETLINE), 32'h0000_5080);
    expect_ev(2, 0, 32'h0000_5080);
    expect_ev(1, 32'(L1_INVALIDATELINE), 32'h0000_5080);
    expect_ev(3, 6, 32'(MESI_I));
    issue(BUS_RWIM, 32'h0000_5093, 4'd7, 1'b1, 3'd6, MESI_M);
    drain();
    l1_stall = 0; wb_stall = 0;

    // INVALIDATE hit S: HIT, INVALIDATELINE, S->I
    expect_ev(0, 32'(SNP_HIT), 32'h0000_8000);
    expect_ev(1, 32'(L1_INVALIDATELINE), 32'h0000_8000);
    expect_ev(3, 4, 32'(MESI_I));
    issue(BUS_INVALIDATE, 32'h0000_8000, 4'd5, 1'b1, 3'd4, MESI_S);
    drain();

    // INVALIDATE hit M: protocol error, NOHIT only
    expect_ev(0, 32'(SNP_NOHIT), 32'h0000_9000);
    issue(BUS_INVALIDATE, 32'h0000_9000, 4'd5, 1'b1, 3'd1, MESI_M);
    drain();

    // WRITE hit M: NOHIT only
    expect_ev(0, 32'(SNP_NOHIT), 32'h0000_A000);
    issue(BUS_WRITE, 32'h0000_A000, 4'd6, 1'b1, 3'd1, MESI_M);
    drain();

    // READ hit S: HIT, no update
    expect_ev(0, 32'(SNP_HIT), 32'h0000_B000);
    issue(BUS_READ, 32'h0000_B000, 4'd6, 1'b1, 3'd1, MESI_S);
    drain();

    repeat (2) @(negedge clk);
`ifdef SNOOP_STATS_EN
    chk("cnt_hit", cnt_hit, 4);
    chk("cnt_hitm", cnt_hitm, 2);
    chk("cnt_nohit", cnt_nohit, 3);
`else
    chk("cnt_hit", cnt_hit, 0);
    chk("cnt_hitm", cnt_hitm, 0);
    chk("cnt_nohit", cnt_nohit, 0);
`endif

    // Reset while the writeback is stalled
    wb_stall = 20;
    expect_ev(0, 32'(SNP_HITM), 32'h0000_7000);
    expect_ev(1, 32'(L1_GETLINE), 32'h0000_7000);
    issue(BUS_READ, 32'h0000_7000, 4'd2, 1'b1, 3'd1, MESI_M);
    n = 0;
    while (!bif.wb_valid && n < 30) begin @(negedge clk); n++; end
    chk("wb_reached", 32'(bif.wb_valid), 1);
    upd_before = upd_cnt;
    #2 rst = 1'b1;
    #1;
    chk("arst_wb_valid", 32'(bif.wb_valid), 0);
    chk("arst_snp_ready", 32'(bif.snp_ready), 1);
    chk("arst_wb_addr", bif.wb_addr, 0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    wb_stall = 0;
    repeat (5) @(negedge clk);
    chk("arst_no_upd", upd_cnt, upd_before);
    chk("arst_cnt_hitm", cnt_hitm, 0);
    chk("arst_cnt_hit", cnt_hit, 0);
    chk("arst_ready_after", 32'(bif.snp_ready), 1);

    // Normal operation resumes after the abort
    expect_ev(0, 32'(SNP_HIT), 32'h0000_C000);
    expect_ev(3, 0, 32'(MESI_S));
    issue(BUS_READ, 32'h0000_C000, 4'd3, 1'b1, 3'd0, MESI_E);
    drain();

    repeat (3) @(negedge clk);
    chk("leftover_expected", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
